// File: rtl/md_hilo_seq_if.sv
// md_hilo_seq_if: request and HI/LO result bundle for the md_hilo_seq
// multiply/divide unit. The master issues start/mdc/a/b and observes
// busy/done/hi/lo; the unit itself connects through the slave modport.
interface md_hilo_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [3:0]   mdc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, mdc, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mdc, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_hilo_seq.sv
// md_hilo_seq: MIPS-style HI/LO multiply/divide unit.
// Multiplies take MUL_LAT cycles, divides run W restoring iterations on
// operand magnitudes followed by one sign-fix cycle, and mthi/mtlo write
// immediately. Defining MD_HILO_MADD_EN adds madd/maddu/msub/msubu, which
// accumulate the product into {hi,lo}; without it those codes do nothing.
module md_hilo_seq #(
  parameter int W       = 32,
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  md_hilo_seq_if.slave bus
);

  localparam int CW = 7;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] opA_q, opA_d;
  logic [W-1:0] opB_q, opB_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         mulSigned_q, mulSigned_d;
  logic         negQ_q, negQ_d;
  logic         negR_q, negR_d;
  logic         divZero_q, divZero_d;
  logic         done_q, done_d;
`ifdef MD_HILO_MADD_EN
  logic         accEn_q, accEn_d;
  logic         accSub_q, accSub_d;
`endif

  logic [2*W-1:0] extA;
  logic [2*W-1:0] extB;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] mulRes;
  logic [W:0]     remShift;
  logic [W:0]     remDiff;
  logic           divSigned;
  logic           negA;
  logic           negB;

  // Next-state, datapath and HI/LO write decisions for the whole unit.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    mulSigned_d = mulSigned_q;
    negQ_d      = negQ_q;
    negR_d      = negR_q;
    divZero_d   = divZero_q;
    done_d      = 1'b0;
`ifdef MD_HILO_MADD_EN
    accEn_d     = accEn_q;
    accSub_d    = accSub_q;
`endif
    divSigned   = 1'b0;
    negA        = 1'b0;
    negB        = 1'b0;

    // Sign- or zero-extend to 2W so the low 2W bits of one unsigned
    // multiply give the correct product for both signednesses.
    extA = mulSigned_q ? {{W{opA_q[W-1]}}, opA_q} : {{W{1'b0}}, opA_q};
    extB = mulSigned_q ? {{W{opB_q[W-1]}}, opB_q} : {{W{1'b0}}, opB_q};
    prod = extA * extB;
`ifdef MD_HILO_MADD_EN
    if (accEn_q) begin
      mulRes = accSub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end else begin
      mulRes = prod;
    end
`else
    mulRes = prod;
`endif

    remShift = {rem_q, quo_q[W-1]};
    remDiff  = remShift - {1'b0, opB_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.mdc)
            OP_MULT, OP_MULTU: begin
              opA_d       = bus.a;
              opB_d       = bus.b;
              mulSigned_d = (bus.mdc == OP_MULT);
              cnt_d       = CW'(MUL_LAT - 1);
`ifdef MD_HILO_MADD_EN
              accEn_d     = 1'b0;
              accSub_d    = 1'b0;
`endif
              state_d     = MUL;
            end
`ifdef MD_HILO_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              opA_d       = bus.a;
              opB_d       = bus.b;
              mulSigned_d = (bus.mdc == OP_MADD) || (bus.mdc == OP_MSUB);
              cnt_d       = CW'(MUL_LAT - 1);
              accEn_d     = 1'b1;
              accSub_d    = (bus.mdc == OP_MSUB) || (bus.mdc == OP_MSUBU);
              state_d     = MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              divSigned = (bus.mdc == OP_DIV);
              negA      = divSigned & bus.a[W-1];
              negB      = divSigned & bus.b[W-1];
              opA_d     = bus.a;
              opB_d     = negB ? -bus.b : bus.b;
              quo_d     = negA ? -bus.a : bus.a;
              rem_d     = '0;
              negQ_d    = negA ^ negB;
              negR_d    = negA;
              divZero_d = (bus.b == '0);
              cnt_d     = CW'(W - 1);
              state_d   = DIV;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end

      MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mulRes;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DIV: begin
        if (!remDiff[W]) begin
          rem_d = remDiff[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = remShift[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIX: begin
        if (divZero_q) begin
          lo_d = '1;
          hi_d = opA_q;
        end else begin
          lo_d = negQ_q ? -quo_q : quo_q;
          hi_d = negR_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      mulSigned_q <= 1'b0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      divZero_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef MD_HILO_MADD_EN
      accEn_q     <= 1'b0;
      accSub_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      mulSigned_q <= mulSigned_d;
      negQ_q      <= negQ_d;
      negR_q      <= negR_d;
      divZero_q   <= divZero_d;
      done_q      <= done_d;
`ifdef MD_HILO_MADD_EN
      accEn_q     <= accEn_d;
      accSub_q    <= accSub_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
